// File: rtl/bpss_seg_pkg.sv
// bpss_seg_pkg: shared types and parameter derivations for the segment sender
package bpss_seg_pkg;
  typedef enum logic [1:0] {IDLE, FILL, SEND, SEND_LAST} state_t;
  // Fields are sized for the widest supported configuration; the top truncates to its own widths.
  typedef struct packed {
    logic [63:0] vaddr;
    logic [31:0] len;
    logic [15:0] pid;
    logic        ctl;
  } wr_req_t;
  function automatic int pmtu_beats(input int pmtu_bytes, input int data_bits);
    return pmtu_bytes / (data_bits / 8);
  endfunction
  function automatic int beat_log_bits(input int beats);
    return $clog2(beats + 1);
  endfunction
endpackage

// File: rtl/bpss_seg_sender_if.sv
// bpss_seg_sender_if: descriptor, write-request and stream buses of the segment sender
interface bpss_seg_sender_if #(
  parameter int DATA_BITS  = 512,
  parameter int VADDR_BITS = 48,
  parameter int PID_BITS   = 6,
  parameter int LEN_BITS   = 28
);
  logic                    t_req_valid;
  logic                    t_req_ready;
  logic [VADDR_BITS-1:0]   t_req_vaddr;
  logic [PID_BITS-1:0]     t_req_pid;
  logic                    wr_req_valid;
  logic                    wr_req_ready;
  logic [VADDR_BITS-1:0]   wr_req_vaddr;
  logic [LEN_BITS-1:0]     wr_req_len;
  logic [PID_BITS-1:0]     wr_req_pid;
  logic                    wr_req_ctl;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic                    s_axis_tlast;
  logic [DATA_BITS-1:0]    s_axis_tdata;
  logic [DATA_BITS/8-1:0]  s_axis_tkeep;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic                    m_axis_tlast;
  logic [DATA_BITS-1:0]    m_axis_tdata;
  logic [DATA_BITS/8-1:0]  m_axis_tkeep;
  modport slave (
    input  t_req_valid, t_req_vaddr, t_req_pid, wr_req_ready,
    input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep, m_axis_tready,
    output t_req_ready, wr_req_valid, wr_req_vaddr, wr_req_len, wr_req_pid, wr_req_ctl,
    output s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep
  );
  modport master (
    output t_req_valid, t_req_vaddr, t_req_pid, wr_req_ready,
    output s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep, m_axis_tready,
    input  t_req_ready, wr_req_valid, wr_req_vaddr, wr_req_len, wr_req_pid, wr_req_ctl,
    input  s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep
  );
endinterface

// File: rtl/bpss_data_fifo.sv
// bpss_data_fifo: synchronous FIFO with a registered output stage
module bpss_data_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             full_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [WIDTH-1:0] rd_data_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] out_q;
  logic             out_vld_q, wr, load;
  assign full_o     = cnt_q == CW'(DEPTH);
  assign wr         = wr_en_i && !full_o;
  assign load       = cnt_q != '0 && (!out_vld_q || rd_ready_i);
  assign rd_valid_o = out_vld_q;
  assign rd_data_o  = out_q;
  // storage array, left unreset since the pointers define what is valid
  always_ff @(posedge aclk)
    if (wr) mem_q[wr_ptr_q] <= wr_data_i;
  // pointers, occupancy and the output register that refills whenever it empties or is consumed
  always_ff @(posedge aclk)
    if (!aresetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      wr_ptr_q  <= wr ? (wr_ptr_q == AW'(DEPTH - 1) ? '0 : wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_q  <= load ? (rd_ptr_q == AW'(DEPTH - 1) ? '0 : rd_ptr_q + AW'(1)) : rd_ptr_q;
      cnt_q     <= cnt_q + CW'(wr) - CW'(load);
      out_vld_q <= load || (out_vld_q && !rd_ready_i);
      out_q     <= load ? mem_q[rd_ptr_q] : out_q;
    end
endmodule

// File: rtl/bpss_seg_sender.sv
// bpss_seg_sender: cuts a descriptor's stream into PMTU segments and issues one write request per segment
module bpss_seg_sender
  import bpss_seg_pkg::*;
#(
  parameter int DATA_BITS  = 512,
  parameter int PMTU_BYTES = 4096,
  parameter int VADDR_BITS = 48,
  parameter int PID_BITS   = 6,
  parameter int LEN_BITS   = 28,
  parameter int FIFO_DEPTH = 2 * pmtu_beats(PMTU_BYTES, DATA_BITS)
) (
  input  logic               aclk,
  input  logic               aresetn,
  bpss_seg_sender_if.slave   bus,
  output logic               busy
);
  localparam int KEEP_BITS  = DATA_BITS / 8;
  localparam int PMTU_BEATS = pmtu_beats(PMTU_BYTES, DATA_BITS);
  localparam int BEAT_BITS  = beat_log_bits(PMTU_BEATS);
  localparam int FIFO_BITS  = DATA_BITS + KEEP_BITS + 1;
  state_t                state_q, state_d;
  logic [VADDR_BITS-1:0] base_q, base_d, off_q, off_d, seg_vaddr;
  logic [PID_BITS-1:0]   pid_q, pid_d;
  logic [LEN_BITS-1:0]   bytes_q, bytes_d;
  logic [BEAT_BITS-1:0]  beats_q, beats_d;
  logic                  fifo_full, fifo_valid, sink_accept, sending;
  logic [FIFO_BITS-1:0]  fifo_dout;
  wr_req_t               req;
  assign seg_vaddr = base_q + off_q;
  assign sending   = state_q == SEND || state_q == SEND_LAST;
  // state and segment bookkeeping registers
  always_ff @(posedge aclk)
    if (!aresetn) begin
      state_q <= IDLE;
      base_q  <= '0;
      off_q   <= '0;
      pid_q   <= '0;
      bytes_q <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      off_q   <= off_d;
      pid_q   <= pid_d;
      bytes_q <= bytes_d;
      beats_q <= beats_d;
    end
  // next-state, segment accounting and handshake outputs; everything is held at zero during reset
  always_comb begin
    state_d           = state_q;
    base_d            = base_q;
    off_d             = off_q;
    pid_d             = pid_q;
    bytes_d           = bytes_q;
    beats_d           = beats_q;
    req               = '0;
    bus.t_req_ready   = aresetn && state_q == IDLE;
    bus.s_axis_tready = aresetn && state_q == FILL && !fifo_full;
    bus.wr_req_valid  = aresetn && sending;
    busy              = aresetn && state_q != IDLE;
    sink_accept       = bus.s_axis_tready && bus.s_axis_tvalid;
    case (state_q)
      IDLE: if (bus.t_req_valid) begin
        base_d  = bus.t_req_vaddr;
        pid_d   = bus.t_req_pid;
        off_d   = '0;
        bytes_d = '0;
        beats_d = '0;
        state_d = FILL;
      end
      FILL: if (sink_accept) begin
        bytes_d = bytes_q + LEN_BITS'($countones(bus.s_axis_tkeep));
        beats_d = beats_q + BEAT_BITS'(1);
        state_d = bus.s_axis_tlast ? SEND_LAST : beats_q == BEAT_BITS'(PMTU_BEATS - 1) ? SEND : FILL;
      end
      default: begin
        req.vaddr = 64'(seg_vaddr);
        req.len   = 32'(bytes_q);
        req.pid   = 16'(pid_q);
        req.ctl   = state_q == SEND_LAST;
        if (bus.wr_req_ready) begin
          off_d   = state_q == SEND ? off_q + VADDR_BITS'(bytes_q) : '0;
          bytes_d = '0;
          beats_d = '0;
          state_d = state_q == SEND ? FILL : IDLE;
        end
      end
    endcase
    if (!aresetn) req = '0;
    bus.wr_req_vaddr = VADDR_BITS'(req.vaddr);
    bus.wr_req_len   = LEN_BITS'(req.len);
    bus.wr_req_pid   = PID_BITS'(req.pid);
    bus.wr_req_ctl   = req.ctl;
  end
  assign bus.m_axis_tvalid = aresetn && fifo_valid;
  assign {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast} = fifo_dout;
  bpss_data_fifo #(.WIDTH(FIFO_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .wr_en_i    (sink_accept),
    .wr_data_i  ({bus.s_axis_tdata, bus.s_axis_tkeep, bus.s_axis_tlast}),
    .full_o     (fifo_full),
    .rd_valid_o (fifo_valid),
    .rd_ready_i (bus.m_axis_tready),
    .rd_data_o  (fifo_dout)
  );
endmodule

// File: tb/tb_bpss_seg_sender.sv
// tb_bpss_seg_sender: scoreboard bench for the segment sender with 4-beat segments
module tb_bpss_seg_sender;
  localparam int DB = 512;
  localparam int KB = DB / 8;
  localparam int PB = 256;
  localparam int NB = PB / KB;
  typedef struct packed {
    logic [47:0] vaddr;
    logic [27:0] len;
    logic [5:0]  pid;
    logic        ctl;
  } req_t;
  typedef logic [DB+KB:0] beat_t;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic busy;
  int   n_checks = 0;
  int   n_errors = 0;
  req_t  wr_exp[$];
  beat_t m_exp[$];
  bit   wr_stall = 0;
  bit   m_stall = 0;
  bit   held_v = 0;
  req_t held;
  bpss_seg_sender_if #(.DATA_BITS(DB), .VADDR_BITS(48), .PID_BITS(6), .LEN_BITS(28)) bus ();
  bpss_seg_sender #(.DATA_BITS(DB), .PMTU_BYTES(PB)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus),
    .busy    (busy)
  );
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected requests derived from the beat count and the final tkeep
  function automatic void plan(input logic [47:0] va, input logic [5:0] pid, input int n, input logic [KB-1:0] last_keep);
    logic [47:0] off = '0;
    int bytes = 0;
    int beats = 0;
    req_t r;
    for (int i = 0; i < n; i++) begin
      bytes += (i == n - 1) ? $countones(last_keep) : KB;
      beats++;
      if (i == n - 1 || beats == NB) begin
        r.vaddr = va + off;
        r.len   = 28'(bytes);
        r.pid   = pid;
        r.ctl   = (i == n - 1);
        wr_exp.push_back(r);
        off += 48'(bytes);
        bytes = 0;
        beats = 0;
      end
    end
  endfunction

  task automatic desc(input logic [47:0] va, input logic [5:0] pid);
    int t = 0;
    bus.t_req_valid = 1'b1;
    bus.t_req_vaddr = va;
    bus.t_req_pid   = pid;
    @(negedge aclk);
    while (!bus.t_req_ready && t < 200) begin
      @(negedge aclk);
      t++;
    end
    check("treq_accept", bus.t_req_ready, 1);
    @(posedge aclk);
    #1 bus.t_req_valid = 1'b0;
  endtask

  task automatic beat(input logic [KB-1:0] keep, input logic last);
    int t = 0;
    logic [DB-1:0] d;
    for (int i = 0; i < DB / 32; i++) d[i*32 +: 32] = $urandom;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = keep;
    bus.s_axis_tlast  = last;
    @(negedge aclk);
    while (!bus.s_axis_tready && t < 300) begin
      @(negedge aclk);
      t++;
    end
    check("sink_accept", bus.s_axis_tready, 1);
    if (bus.s_axis_tready) m_exp.push_back({d, keep, last});
    @(posedge aclk);
    #1 bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic beats(input int n, input logic [KB-1:0] last_keep);
    for (int i = 0; i < n; i++) beat(i == n - 1 ? last_keep : '1, i == n - 1);
  endtask

  task automatic drain();
    int t = 0;
    while ((wr_exp.size() != 0 || m_exp.size() != 0) && t < 500) begin
      @(negedge aclk);
      t++;
    end
    check("drain_wr", wr_exp.size(), 0);
    check("drain_m", m_exp.size(), 0);
    @(negedge aclk);
    check("busy_idle", busy, 0);
    @(posedge aclk);
    #1;
  endtask

  task automatic run(input logic [47:0] va, input logic [5:0] pid, input int n, input logic [KB-1:0] last_keep);
    plan(va, pid, n, last_keep);
    desc(va, pid);
    beats(n, last_keep);
    drain();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    wr_exp.delete();
    m_exp.delete();
    repeat (2) @(negedge aclk);
    check("rst_treq_ready", bus.t_req_ready, 0);
    check("rst_sink_ready", bus.s_axis_tready, 0);
    check("rst_wr_valid", bus.wr_req_valid, 0);
    check("rst_m_valid", bus.m_axis_tvalid, 0);
    check("rst_busy", busy, 0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("idle_treq_ready", bus.t_req_ready, 1);
    check("idle_busy", busy, 0);
    @(posedge aclk);
    #1;
  endtask

  // randomized back-pressure, forced low while the matching stall flag is set
  initial begin
    bus.wr_req_ready = 1'b0;
    bus.m_axis_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      bus.wr_req_ready  = !wr_stall && ($urandom_range(3) != 0);
      bus.m_axis_tready = !m_stall && ($urandom_range(3) != 0);
    end
  end

  // request monitor: scoreboard compare, stability while stalled, zero fields while idle
  always @(negedge aclk) begin
    req_t cur;
    req_t e;
    cur = {bus.wr_req_vaddr, bus.wr_req_len, bus.wr_req_pid, bus.wr_req_ctl};
    if (bus.wr_req_valid) begin
      if (held_v) check("wr_stable", cur, held);
      if (bus.wr_req_ready) begin
        check("wr_queue", wr_exp.size() != 0, 1);
        if (wr_exp.size() != 0) begin
          e = wr_exp.pop_front();
          check("wr_vaddr", cur.vaddr, e.vaddr);
          check("wr_len", cur.len, e.len);
          check("wr_pid", cur.pid, e.pid);
          check("wr_ctl", cur.ctl, e.ctl);
        end
        held_v = 0;
      end else begin
        held   = cur;
        held_v = 1;
      end
    end else begin
      held_v = 0;
      check("wr_idle_zero", cur, 0);
    end
  end

  // stream monitor: every beat leaving m_axis must match the next accepted sink beat
  always @(negedge aclk) begin
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      check("m_queue", m_exp.size() != 0, 1);
      if (m_exp.size() != 0) check("m_beat", {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast}, m_exp.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.t_req_valid   = 1'b0;
    bus.t_req_vaddr   = '0;
    bus.t_req_pid     = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tlast  = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    do_reset();
    run(48'h1000, 6'h03, 10, '1);
    run(48'h2000, 6'h15, 3, 64'h0000_0000_FFFF_FFFF);
    wr_stall = 1;
    plan(48'h3000, 6'h2a, 4, '1);
    desc(48'h3000, 6'h2a);
    beats(4, '1);
    @(negedge aclk);
    check("wr_valid_next", bus.wr_req_valid, 1);
    repeat (3) @(negedge aclk);
    check("treq_blocked", bus.t_req_ready, 0);
    check("busy_hold", busy, 1);
    @(posedge aclk);
    #1 wr_stall = 0;
    drain();
    wr_stall = 1;
    m_stall = 1;
    plan(48'h4000, 6'h07, 12, '1);
    desc(48'h4000, 6'h07);
    fork
      beats(12, '1);
      begin
        repeat (25) @(negedge aclk);
        check("send_sink_off", bus.s_axis_tready, 0);
        check("stall_valid", bus.wr_req_valid, 1);
        wr_stall = 0;
        repeat (40) @(negedge aclk);
        check("full_sink_off", bus.s_axis_tready, 0);
        check("full_busy", busy, 1);
        m_stall = 0;
      end
    join
    drain();
    desc(48'h9000, 6'h11);
    beat('1, 1'b0);
    beat('1, 1'b0);
    do_reset();
    run(48'h5000, 6'h21, 5, 64'hFF);
    run(48'hFFFF_FFFF_FF80, 6'h3f, 8, '1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bpss_seg_sender.md
BPSS_SEG_SENDER -- requirements
Module: bpss_seg_sender

Interface
REQ-001 SHALL have parameter DATA_BITS, default 512: stream data width; power of two, at least 64.
REQ-002 SHALL have parameter PMTU_BYTES, default 4096: maximum segment size; integer multiple of DATA_BITS/8.
REQ-003 SHALL have parameters VADDR_BITS 48, PID_BITS 6 and LEN_BITS 28; LEN_BITS SHALL be at least clog2(PMTU_BYTES)+1.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2*PMTU_BEATS, where PMTU_BEATS = PMTU_BYTES/(DATA_BITS/8).
REQ-005 aclk  in  1  clock; all logic rising-edge.
REQ-006 aresetn  in  1  reset, synchronous, active-low.
REQ-007 t_req_valid/t_req_ready  in/out  1/1  descriptor handshake.
REQ-008 t_req_vaddr  in  VADDR_BITS  base virtual address; t_req_pid  in  PID_BITS  process id.
REQ-009 wr_req_valid/wr_req_ready  out/in  1/1  segment write-request handshake.
REQ-010 wr_req_vaddr  out  VADDR_BITS; wr_req_len  out  LEN_BITS (bytes); wr_req_pid  out  PID_BITS; wr_req_ctl  out  1 (last segment).
REQ-011 s_axis_tvalid/tready/tlast  in/out/in  1; s_axis_tdata  in  DATA_BITS; s_axis_tkeep  in  DATA_BITS/8.
REQ-012 m_axis_tvalid/tready/tlast  out/in/out  1; m_axis_tdata  out  DATA_BITS; m_axis_tkeep  out  DATA_BITS/8.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, FILL, SEND and SEND_LAST.
REQ-015 IDLE: t_req_ready=1; on t_req_valid, latch vaddr/pid, clear offset, byte and beat counters, go to FILL.
REQ-016 FILL: s_axis_tready = FIFO not full; other states: s_axis_tready=0.
REQ-017 FILL, accepted beat: write {tdata,tkeep,tlast} to FIFO; bytes += popcount(tkeep); beats += 1.
REQ-018 FILL transitions: accepted beat with tlast -> SEND_LAST (tlast has priority); otherwise accepted beat with beats==PMTU_BEATS-1 -> SEND.
REQ-019 SEND/SEND_LAST: wr_req_valid=1, vaddr=base+offset (mod 2^VADDR_BITS), len=bytes, pid=latched pid; ctl=0 in SEND, 1 in SEND_LAST.
REQ-020 wr_req fields SHALL stay stable while valid and not ready.
REQ-021 SEND on wr_req_ready: offset += bytes; clear bytes and beats; go to FILL.
REQ-022 SEND_LAST on wr_req_ready: clear offset, bytes and beats; go to IDLE.
REQ-023 wr_req_valid SHALL assert the cycle after the beat that closes a segment.
REQ-024 Outside SEND/SEND_LAST: wr_req_valid=0, and all wr_req fields SHALL be 0.
REQ-025 m_axis SHALL drain the FIFO independently of FSM state; a written beat SHALL appear on m_axis no earlier than 1 cycle after write.
REQ-026 FIFO full SHALL stall the sink without loss; the FIFO SHALL never overflow or underflow.
REQ-027 tlast on the PMTU_BEATS-th beat SHALL yield one request with len=PMTU_BYTES and ctl=1, never an extra zero-length request.

Reset
REQ-028 While aresetn=0: state=IDLE; counters, offset, base and pid = 0; FIFO flushed.
REQ-029 While aresetn=0: all valid/ready outputs = 0, busy=0, and wr_req fields = 0.
REQ-030 Reset asserted mid-segment SHALL discard the partial segment without emitting a request.

Structure
REQ-031 Package bpss_seg_pkg SHALL hold state_t, the wr_req struct (vaddr, len, pid, ctl) and the PMTU_BEATS/BEAT_LOG_BITS derivation functions.
REQ-032 A single sub-module bpss_data_fifo SHALL implement the synchronous FIFO: width DATA_BITS+DATA_BITS/8+1, depth FIFO_DEPTH, registered output, synchronous reset.

Verification (DATA_BITS=512, PMTU_BYTES=256, i.e. 4 beats)
REQ-033 Desc vaddr=0x1000, 10 full beats, tlast on beat 10 -> requests (0x1000,256,ctl0), (0x1100,256,ctl0), (0x1200,128,ctl1); busy drops after the third.
REQ-034 Desc vaddr=0x2000, 3 beats, last tkeep=0x0000_0000_FFFF_FFFF -> one request (0x2000,160,ctl1); m_axis carries identical tkeep.
REQ-035 Exactly 4 beats with tlast on beat 4 -> single request (base,256,ctl1); next t_req accepted only after its handshake.
REQ-036 wr_req_ready held 0 for 20 cycles and m_axis_tready=0 -> sink stalls when FIFO full; fields stable; no beat lost after release.
REQ-037 aresetn pulsed low mid-segment after beat 2 -> no request issued; outputs 0; new descriptor processed correctly from offset 0.
REQ-038 Base vaddr=2^48-0x80 with 256-byte segments -> second request vaddr=0x80, wrapped modulo 2^48.
